// File: rtl/seven_segment_scan_controller.sv
// ----------------------------------------------------------------------------
// seven_segment_scan_controller
//
// Time-multiplexed scan controller for a NUM_DIGITS-digit common-anode
// seven-segment display. A bank of DATA_WIDTH-bit digit values is scanned one
// digit per slot of REFRESH_CYCLES clocks onto a shared active-low segment
// bus. The first BLANK_CYCLES of every slot are blanked to suppress ghosting.
// New digit banks arrive over a valid/ready handshake into a pending buffer
// and are only committed to the displayed bank at a frame boundary.
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   load_valid  a new digit bank is offered
//   load_data   digit k lives in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   load_ready  pending buffer empty, a load can be accepted
//   digit_en    per-digit enable, sampled live
//   seg_out     active-low segments {g,f,e,d,c,b,a} of the scanned digit
//   anode_out   active-low digit select, at most one bit low
//   scan_index  digit currently being scanned
//   frame_tick  one-cycle pulse at each frame start
// ----------------------------------------------------------------------------
module seven_segment_scan_controller #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned DATA_WIDTH     = 3,
   parameter int unsigned RESULT_WIDTH   = 7,
   parameter int unsigned REFRESH_CYCLES = 1000,
   parameter int unsigned BLANK_CYCLES   = 16,
   localparam int unsigned IDX_W         = $clog2(NUM_DIGITS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             load_valid,
   input  logic [NUM_DIGITS*DATA_WIDTH-1:0] load_data,
   output logic                             load_ready,
   input  logic [NUM_DIGITS-1:0]            digit_en,
   output logic [RESULT_WIDTH-1:0]          seg_out,
   output logic [NUM_DIGITS-1:0]            anode_out,
   output logic [IDX_W-1:0]                 scan_index,
   output logic                             frame_tick
);

   localparam int unsigned SLOT_W = $clog2(REFRESH_CYCLES);
   localparam int unsigned BANK_W = NUM_DIGITS * DATA_WIDTH;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_CYCLES - 1);
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } slot_state_e;

   localparam slot_state_e ST_RESET = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

   // Segment glyph for digit values 0..7; anything else is dark.
   function automatic logic [RESULT_WIDTH-1:0] glyph(input logic [DATA_WIDTH-1:0] v);
      logic [6:0] g;
      case (32'(v))
         0:       g = 7'b1000000;
         1:       g = 7'b1111001;
         2:       g = 7'b0100100;
         3:       g = 7'b0110000;
         4:       g = 7'b0011001;
         5:       g = 7'b0010010;
         6:       g = 7'b0000010;
         7:       g = 7'b1111000;
         default: g = 7'b1111111;
      endcase
      return RESULT_WIDTH'(g);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [SLOT_W-1:0]       slot_cnt_q,     slot_cnt_d;
   logic [IDX_W-1:0]        digit_idx_q,    digit_idx_d;
   slot_state_e             state_q,        state_d;
   logic [BANK_W-1:0]       active_q,       active_d;
   logic [BANK_W-1:0]       pending_q,      pending_d;
   logic                    pending_full_q, pending_full_d;
   logic [RESULT_WIDTH-1:0] seg_q,          seg_d;
   logic [NUM_DIGITS-1:0]   anode_q,        anode_d;
   logic [IDX_W-1:0]        scan_index_q,   scan_index_d;
   logic                    frame_tick_q,   frame_tick_d;

   logic slot_wrap;
   logic frame_wrap;
   logic accept;
   logic commit;

   // ------------------------------------------------------------------
   // Scan counters and load/commit datapath
   // ------------------------------------------------------------------
   always_comb begin
      slot_wrap  = (slot_cnt_q == SLOT_LAST);
      frame_wrap = slot_wrap && (digit_idx_q == IDX_LAST);

      slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
      digit_idx_d = digit_idx_q;
      if (slot_wrap) begin
         digit_idx_d = frame_wrap ? '0 : digit_idx_q + 1'b1;
      end

      // Accept and commit are mutually exclusive: accept needs an empty
      // pending buffer, commit needs a full one.
      accept = load_valid && !pending_full_q;
      commit = frame_wrap && pending_full_q;

      pending_d      = accept ? load_data : pending_q;
      active_d       = commit ? pending_q : active_q;
      pending_full_d = pending_full_q;
      if (accept) begin
         pending_full_d = 1'b1;
      end else if (commit) begin
         pending_full_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Per-slot FSM: next-state logic
   // ------------------------------------------------------------------
   // The state tracks the counter value it is paired with, so it is
   // derived from the next slot count rather than the current one.
   always_comb begin
      state_d = (slot_cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
   end

   // ------------------------------------------------------------------
   // Per-slot FSM: output logic (registered one cycle later)
   // ------------------------------------------------------------------
   always_comb begin
      logic [DATA_WIDTH-1:0] cur_val;
      logic                  cur_en;

      cur_val = '0;
      cur_en  = 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (digit_idx_q == IDX_W'(k)) begin
            cur_val = active_q[k*DATA_WIDTH +: DATA_WIDTH];
            cur_en  = digit_en[k];
         end
      end

      seg_d   = '1;
      anode_d = '1;
      if ((state_q == ST_SHOW) && cur_en) begin
         seg_d   = glyph(cur_val);
         anode_d = ~(NUM_DIGITS'(1) << digit_idx_q);
      end

      scan_index_d = digit_idx_q;
      frame_tick_d = (slot_cnt_q == '0) && (digit_idx_q == '0);
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q     <= '0;
         digit_idx_q    <= '0;
         state_q        <= ST_RESET;
         active_q       <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         seg_q          <= '1;
         anode_q        <= '1;
         scan_index_q   <= '0;
         frame_tick_q   <= 1'b0;
      end else begin
         slot_cnt_q     <= slot_cnt_d;
         digit_idx_q    <= digit_idx_d;
         state_q        <= state_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         seg_q          <= seg_d;
         anode_q        <= anode_d;
         scan_index_q   <= scan_index_d;
         frame_tick_q   <= frame_tick_d;
      end
   end

   assign load_ready = ~pending_full_q;
   assign seg_out    = seg_q;
   assign anode_out  = anode_q;
   assign scan_index = scan_index_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_seven_segment_scan_controller
//
// Directed bench for seven_segment_scan_controller with NUM_DIGITS=4,
// REFRESH_CYCLES=8, BLANK_CYCLES=2. A cycle-level reference (counter cycle
// index -> slot/digit, pending/active bank) predicts every output each cycle;
// hand-written tables cover the scan sequence, disable and reset cases.
// ----------------------------------------------------------------------------
module tb_seven_segment_scan_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid;
   logic [11:0] load_data;
   logic        load_ready;
   logic [3:0]  digit_en;
   logic [6:0]  seg_out;
   logic [3:0]  anode_out;
   logic [1:0]  scan_index;
   logic        frame_tick;

   always #5 clk = ~clk;

   seven_segment_scan_controller #(
      .NUM_DIGITS    (4),
      .DATA_WIDTH    (3),
      .RESULT_WIDTH  (7),
      .REFRESH_CYCLES(8),
      .BLANK_CYCLES  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_valid(load_valid),
      .load_data (load_data),
      .load_ready(load_ready),
      .digit_en  (digit_en),
      .seg_out   (seg_out),
      .anode_out (anode_out),
      .scan_index(scan_index),
      .frame_tick(frame_tick)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference state: t = counter cycle index of the next active edge.
   int          t;
   logic [11:0] m_active;
   logic [11:0] m_pending;
   bit          m_full;

   bit   ok;
   int   falls;
   int   an_f;
   logic prev_ready;
   logic [3:0] an_tbl  [4];
   logic [6:0] seg_tbl [4];

   function automatic logic [6:0] glyph_ref(input logic [2:0] v);
      case (v)
         3'd0: return 7'b1000000;
         3'd1: return 7'b1111001;
         3'd2: return 7'b0100100;
         3'd3: return 7'b0110000;
         3'd4: return 7'b0011001;
         3'd5: return 7'b0010010;
         3'd6: return 7'b0000010;
         3'd7: return 7'b1111000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: predict outputs for counter cycle t, update the reference
   // bank state on the edge, then compare on the falling edge.
   task automatic cyc();
      int         c, slot, dig;
      logic [6:0] es;
      logic [3:0] ea;
      logic       etick;
      logic [1:0] eidx;
      @(posedge clk);
      c    = t;
      slot = c % 8;
      dig  = (c / 8) % 4;
      if (slot < 2 || !digit_en[dig]) begin
         es = 7'h7F;
         ea = 4'hF;
      end else begin
         es = glyph_ref(m_active[dig*3 +: 3]);
         ea = ~(4'b0001 << dig);
      end
      etick = (c % 32 == 0);
      eidx  = 2'(dig);
      if (load_valid && !m_full) begin
         m_pending = load_data;
         m_full    = 1'b1;
      end else if (m_full && (c % 32 == 31)) begin
         m_active = m_pending;
         m_full   = 1'b0;
      end
      t++;
      @(negedge clk);
      chk("seg_out",    32'(seg_out),    32'(es));
      chk("anode_out",  32'(anode_out),  32'(ea));
      chk("scan_index", 32'(scan_index), 32'(eidx));
      chk("frame_tick", 32'(frame_tick), 32'(etick));
      chk("load_ready", 32'(load_ready), 32'(!m_full));
      chk("one_anode",  32'($onehot0(~anode_out)), 32'd1);
   endtask

   // Run cycles until frame_tick is seen, bounded to two frames.
   task automatic wait_tick();
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         cyc();
         if (frame_tick) begin
            ok = 1'b1;
            break;
         end
      end
      chk("tick_seen", 32'(ok), 32'd1);
   endtask

   // Asynchronous reset asserted mid-cycle, released on a falling edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_seg",   32'(seg_out),    32'h7F);
      chk("rst_anode", 32'(anode_out),  32'hF);
      chk("rst_ready", 32'(load_ready), 32'd1);
      chk("rst_tick",  32'(frame_tick), 32'd0);
      chk("rst_index", 32'(scan_index), 32'd0);
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      t         = 0;
      m_active  = '0;
      m_pending = '0;
      m_full    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      an_tbl[0]  = 4'b1110; an_tbl[1]  = 4'b1101; an_tbl[2]  = 4'b1011; an_tbl[3]  = 4'b0111;
      seg_tbl[0] = 7'b1111001; seg_tbl[1] = 7'b0100100;
      seg_tbl[2] = 7'b0110000; seg_tbl[3] = 7'b1111000;

      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      digit_en   = 4'hF;
      t          = 0;
      m_active   = '0;
      m_pending  = '0;
      m_full     = 1'b0;

      // Power-on reset
      repeat (2) @(negedge clk);
      chk("por_seg",   32'(seg_out),    32'h7F);
      chk("por_anode", 32'(anode_out),  32'hF);
      chk("por_ready", 32'(load_ready), 32'd1);
      chk("por_tick",  32'(frame_tick), 32'd0);
      rst_n = 1'b1;

      // First tick one cycle after the first counter cycle, then every 32
      cyc();
      chk("first_tick", 32'(frame_tick), 32'd1);
      repeat (31) cyc();
      cyc();
      chk("tick_period", 32'(frame_tick), 32'd1);

      // Reset held mid-frame
      repeat (19) cyc();
      do_reset();
      cyc();
      chk("first_tick_after_rst", 32'(frame_tick), 32'd1);

      // Basic scan of 12'hED1 -> digits 1,2,3,7
      load_valid = 1'b1;
      load_data  = 12'hED1;
      cyc();
      load_valid = 1'b0;
      load_data  = '0;
      chk("ready_fall", 32'(load_ready), 32'd0);
      wait_tick();
      for (int s = 0; s < 32; s++) begin
         if (s > 0) cyc();
         if (s % 8 < 2) begin
            chk("scan_blank_anode", 32'(anode_out), 32'hF);
            chk("scan_blank_seg",   32'(seg_out),   32'h7F);
         end else begin
            chk("scan_anode", 32'(anode_out), 32'(an_tbl[s/8]));
            chk("scan_seg",   32'(seg_out),   32'(seg_tbl[s/8]));
         end
      end

      // Tearing: valid held high, data changing every cycle
      wait_tick();
      load_valid = 1'b1;
      falls      = 0;
      prev_ready = load_ready;
      for (int i = 0; i < 95; i++) begin
         load_data = 12'($urandom);
         cyc();
         if (prev_ready && !load_ready) falls++;
         prev_ready = load_ready;
      end
      load_valid = 1'b0;
      chk("accepts_per_3_frames", 32'(falls), 32'd3);

      // Disable digit 2
      digit_en = 4'b1011;
      wait_tick();
      an_f = 0;
      for (int s = 0; s < 32; s++) begin
         if (s > 0) cyc();
         if (anode_out == 4'hF) an_f++;
         if (s / 8 == 2) begin
            chk("dis_anode", 32'(anode_out), 32'hF);
            chk("dis_seg",   32'(seg_out),   32'h7F);
         end
      end
      cyc();
      chk("dis_frame_len", 32'(frame_tick), 32'd1);
      chk("dis_blank_cnt", 32'(an_f), 32'd14);

      // Reset with a load pending
      digit_en = 4'hF;
      wait_tick();
      load_valid = 1'b1;
      load_data  = 12'hFFF;
      cyc();
      load_valid = 1'b0;
      chk("mid_ready_low", 32'(load_ready), 32'd0);
      repeat (5) cyc();
      do_reset();
      repeat (3) cyc();
      chk("after_rst_seg",   32'(seg_out),    32'b1000000);
      chk("after_rst_anode", 32'(anode_out),  32'b1110);
      chk("after_rst_ready", 32'(load_ready), 32'd1);
      repeat (40) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/seven_segment_scan_controller.md
# seven_segment_scan_controller

Time-multiplexed scan controller for a NUM_DIGITS-digit common-anode seven-segment display. It sits between the adder result logic and the board display pins. It holds a bank of 3-bit digit values and rotates one digit at a time onto a shared active-low segment bus, using the standard 0–7 glyph table. Each digit slot starts with an anti-ghosting blanking interval. Digit updates arrive over a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new values.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits; ≥2.
- DATA_WIDTH, 3: bits per digit value.
- RESULT_WIDTH, 7: segment bus width, order {g,f,e,d,c,b,a}, active-low.
- REFRESH_CYCLES, 1000: clock cycles per digit slot; ≥2.
- BLANK_CYCLES, 16: blanked cycles at the start of each slot; must be < REFRESH_CYCLES.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load_valid  in  1  a new digit bank is offered.
- load_data  in  NUM_DIGITS*DATA_WIDTH  digit k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- load_ready  out  1  pending buffer is empty, so a load can be accepted.
- digit_en  in  NUM_DIGITS  per-digit enable; sampled live, not buffered.
- seg_out  out  RESULT_WIDTH  active-low segments of the currently scanned digit.
- anode_out  out  NUM_DIGITS  active-low digit select; at most one bit low.
- scan_index  out  clog2(NUM_DIGITS)  digit currently being scanned.
- frame_tick  out  1  one-cycle pulse at every frame start.

## Operation
- Counters:
  - slot_cnt runs 0..REFRESH_CYCLES-1.
  - digit_idx runs 0..NUM_DIGITS-1 and increments when slot_cnt wraps.
  - digit_idx wraps from NUM_DIGITS-1 to 0. This is the frame boundary.
- Per-slot state machine, for the slot of digit k:
  - BLANK (slot_cnt < BLANK_CYCLES): anodes all 1, seg_out = 7'b1111111.
  - SHOW (slot_cnt ≥ BLANK_CYCLES): if digit_en[k]=1, anode k = 0 and seg_out = glyph(active[k]).
  - SHOW with digit_en[k]=0: same as BLANK, but the slot still occupies REFRESH_CYCLES (constant frame length).
  - SHOW → BLANK on slot wrap.
- Glyph table: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000. Any other value → 1111111.
- Load handshake:
  - A transfer occurs on an edge with load_valid && load_ready.
  - load_data is captured into pending, pending_full is set, and load_ready drops.
  - load_valid may stay high. No further accepts occur until pending is committed.
- Commit: on the frame-boundary edge with pending_full=1, active ← pending, pending_full clears, and load_ready rises.
- No simultaneous accept and commit is possible, because ready is low while pending is full.
- Reset mid-operation: all counters, active bank, pending and outputs return to reset values immediately, and any in-flight pending data is discarded.

## Timing
- Reset values:
  - seg_out = all 1.
  - anode_out = all 1.
  - load_ready = 1.
  - scan_index = 0.
  - frame_tick = 0.
  - active bank = 0.
  - pending_full = 0.
- First frame starts with slot_cnt=0, digit_idx=0 on the first edge after rst_n deasserts.
- All outputs are registered and lag the counter state they reflect by 1 cycle.
- Slot k of frame f occupies counter cycles [f*F + k*REFRESH_CYCLES, +REFRESH_CYCLES), where F = NUM_DIGITS*REFRESH_CYCLES.
- anode k is low for REFRESH_CYCLES−BLANK_CYCLES consecutive cycles per frame.
- frame_tick is high for the single output cycle corresponding to slot_cnt=0, digit_idx=0. The first pulse comes 1 cycle after the first counter cycle.
- Load latency: data accepted in frame f is displayed from frame f+1. load_ready returns high on the frame-boundary edge.
- digit_en changes take effect with 1-cycle output latency, including mid-slot.

## Test plan
Parameters: NUM_DIGITS=4, REFRESH_CYCLES=8, BLANK_CYCLES=2.
- Reset: hold rst_n=0 mid-frame.
  - Required: seg_out=7'h7F, anode_out=4'hF, load_ready=1 asynchronously.
  - Required after release: frame_tick pulse 1 cycle after the first counter cycle, repeating every 32 cycles.
- Basic scan: load 12'hED1 (digits 1,2,3,7), all enabled.
  - Required from the next frame: anode_out=1110 / seg 1111001 for 6 cycles after 2 blank cycles.
  - Then 1101/0100100, then 1011/0110000, then 0111/1111000.
- Tearing: hold load_valid=1 continuously and change load_data every cycle mid-frame.
  - Required: exactly one accept per frame, and the displayed values stay constant within a frame.
  - Required: load_ready falls the cycle after accept and rises at the frame boundary.
- Disable: digit_en=4'b1011.
  - Required: digit 2's slot shows anode_out=4'hF and seg 7'h7F for all 8 cycles.
  - Required: the other slots are unchanged and the frame is still 32 cycles.
- Blanking: check that no cycle ever has two anode bits low, and that every slot's first 2 cycles have anode_out=4'hF.
- Reset mid-load: accept a load, then assert rst_n before the frame boundary.
  - Required after release: the active bank stays all zero (all digits show 1000000), and load_ready=1.
